// File: rtl/johnson_monitor.sv
// Receive-side checker for an 8-bit Johnson counter bus: decodes each
// sampled code, checks for +1 steps, acquires lock and counts errors.
module johnson_monitor #(
   parameter int LOCK_COUNT = 4,
   parameter int ERR_WIDTH  = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [7:0]           jc_in,
   input  logic                 sample_en,
   input  logic                 clear_err,
   output logic [3:0]           index,
   output logic                 code_valid,
   output logic                 locked,
   output logic                 err_pulse,
   output logic                 wrap_pulse,
   output logic [ERR_WIDTH-1:0] err_count
);

   typedef enum logic {
      S_SEARCH = 1'b0,
      S_LOCKED = 1'b1
   } state_e;

   state_e               state_q, state_d;
   logic [3:0]           prev_idx_q, prev_idx_d;
   logic                 prev_ok_q, prev_ok_d;
   logic [3:0]           run_q, run_d;
   logic [ERR_WIDTH-1:0] err_q, err_d;
   logic                 errp_q, errp_d;
   logic                 wrap_q, wrap_d;

   logic [3:0]           dec_idx;
   logic                 dec_ok;
   logic [3:0]           nxt_idx;
   logic [4:0]           run_inc;
   logic [ERR_WIDTH-1:0] cnt_base;
   logic                 good;

   // Code for index k: low k ones for k<=8, then ones shifted up by k-8.
   function automatic logic [7:0] jc_code(input logic [3:0] k);
      logic [15:0] t;
      if (k <= 4'd8) t = 16'h00FF >> (4'd8 - k);
      else           t = 16'h00FF << (k - 4'd8);
      return t[7:0];
   endfunction

   always_comb begin
      dec_idx = 4'd0;
      dec_ok  = 1'b0;
      for (int k = 0; k < 16; k++) begin
         if (jc_in == jc_code(4'(k))) begin
            dec_idx = 4'(k);
            dec_ok  = 1'b1;
         end
      end
   end

   assign nxt_idx = prev_idx_q + 4'd1;
   assign run_inc = {1'b0, run_q} + 5'd1;
   assign good    = prev_ok_q && dec_ok && (dec_idx == nxt_idx);

   always_comb begin
      state_d    = state_q;
      prev_idx_d = prev_idx_q;
      prev_ok_d  = prev_ok_q;
      run_d      = run_q;
      errp_d     = 1'b0;
      wrap_d     = 1'b0;
      cnt_base   = clear_err ? '0 : err_q;
      err_d      = cnt_base;
      if (sample_en) begin
         unique case (state_q)
            S_SEARCH: begin
               if (good && run_inc == 5'(LOCK_COUNT)) begin
                  state_d = S_LOCKED;
                  run_d   = 4'd0;
               end else if (good) begin
                  run_d = run_inc[3:0];
               end else begin
                  run_d = 4'd0;
               end
            end
            S_LOCKED: begin
               if (good) begin
                  wrap_d = (prev_idx_q == 4'hF) && (dec_idx == 4'd0);
               end else begin
                  errp_d  = 1'b1;
                  state_d = S_SEARCH;
                  run_d   = 4'd0;
                  // clear wins first, then the error still counts
                  if (~&cnt_base) err_d = cnt_base + 1'b1;
               end
            end
         endcase
         prev_ok_d  = dec_ok;
         prev_idx_d = dec_idx;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_SEARCH;
         prev_idx_q <= 4'd0;
         prev_ok_q  <= 1'b0;
         run_q      <= 4'd0;
         err_q      <= '0;
         errp_q     <= 1'b0;
         wrap_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         prev_idx_q <= prev_idx_d;
         prev_ok_q  <= prev_ok_d;
         run_q      <= run_d;
         err_q      <= err_d;
         errp_q     <= errp_d;
         wrap_q     <= wrap_d;
      end
   end

   assign index      = prev_idx_q;
   assign code_valid = prev_ok_q;
   assign locked     = (state_q == S_LOCKED);
   assign err_pulse  = errp_q;
   assign wrap_pulse = wrap_q;
   assign err_count  = err_q;

endmodule

// File: tb/tb_johnson_monitor.sv
// Bench for johnson_monitor: directed scenarios plus random stimulus
// compared against an arithmetic reference model.
module tb_johnson_monitor;

   localparam int LOCK = 4;
   localparam int EW   = 8;
   localparam int EMAX = (1 << EW) - 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [7:0]    jc_in = 8'h00;
   logic          sample_en = 1'b0;
   logic          clear_err = 1'b0;
   logic [3:0]    index;
   logic          code_valid;
   logic          locked;
   logic          err_pulse;
   logic          wrap_pulse;
   logic [EW-1:0] err_count;

   int n_chk  = 0;
   int n_pass = 0;

   // reference model state
   bit m_locked, m_prevv, m_errp, m_wrap;
   int m_prev, m_run, m_err;

   always #5 clk = ~clk;

   johnson_monitor #(.LOCK_COUNT(LOCK), .ERR_WIDTH(EW)) dut (
      .clk(clk), .rst_n(rst_n), .jc_in(jc_in),
      .sample_en(sample_en), .clear_err(clear_err),
      .index(index), .code_valid(code_valid), .locked(locked),
      .err_pulse(err_pulse), .wrap_pulse(wrap_pulse),
      .err_count(err_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0d, want %0d (t=%0t)",
                    tag, obs, exp, $time);
   endtask

   function automatic logic [7:0] ref_code(input int k);
      int v;
      v = (k <= 8) ? ((1 << k) - 1) : (255 & (255 << (k - 8)));
      return 8'(v);
   endfunction

   // Decode by population count: a legal code is a run of ones at the
   // bottom (index = count) or at the top (index = 16 - count).
   task automatic ref_decode(input logic [7:0] c, output bit ok,
                             output int idx);
      int p;
      p = $countones(c);
      ok = 1'b0;
      idx = 0;
      if (int'(c) == ((1 << p) - 1)) begin
         ok = 1'b1; idx = p;
      end else if (int'(c) == (255 & (255 << (8 - p)))) begin
         ok = 1'b1; idx = 16 - p;
      end
   endtask

   task automatic model_reset();
      m_locked = 0; m_prevv = 0; m_errp = 0; m_wrap = 0;
      m_prev = 0; m_run = 0; m_err = 0;
   endtask

   task automatic model_step(input logic [7:0] c, input bit en,
                             input bit clr);
      bit ok, good;
      int cur;
      m_errp = 0;
      m_wrap = 0;
      if (clr) m_err = 0;
      if (en) begin
         ref_decode(c, ok, cur);
         good = m_prevv && ok && (cur == (m_prev + 1) % 16);
         if (!m_locked) begin
            if (good) begin
               m_run++;
               if (m_run == LOCK) begin m_locked = 1; m_run = 0; end
            end else m_run = 0;
         end else if (good) begin
            m_wrap = (m_prev == 15 && cur == 0);
         end else begin
            m_errp = 1;
            if (m_err < EMAX) m_err++;
            m_locked = 0;
            m_run = 0;
         end
         m_prevv = ok;
         m_prev = ok ? cur : 0;
      end
   endtask

   task automatic cmp_model();
      chk("index", 32'(index), 32'(m_prev));
      chk("code_valid", 32'(code_valid), 32'(m_prevv));
      chk("locked", 32'(locked), 32'(m_locked));
      chk("err_pulse", 32'(err_pulse), 32'(m_errp));
      chk("wrap_pulse", 32'(wrap_pulse), 32'(m_wrap));
      chk("err_count", 32'(err_count), 32'(m_err));
   endtask

   task automatic step(input logic [7:0] c, input bit en, input bit clr);
      @(negedge clk);
      jc_in = c;
      sample_en = en;
      clear_err = clr;
      @(posedge clk);
      model_step(c, en, clr);
      #1;
      cmp_model();
      jc_in = 8'h00;
      sample_en = 1'b0;
      clear_err = 1'b0;
   endtask

   task automatic seq(input int start, input int n);
      for (int i = 0; i < n; i++) step(ref_code((start + i) % 16), 1, 0);
   endtask

   initial begin
      model_reset();
      #3;
      chk("rst_locked", 32'(locked), 0);
      chk("rst_err", 32'(err_count), 0);
      @(negedge clk);
      rst_n = 1'b1;
      step(8'h00, 0, 0);

      // acquisition from index 0
      seq(0, 4);
      chk("acq_not_yet", 32'(locked), 0);
      seq(4, 1);
      chk("acq_locked", 32'(locked), 1);
      chk("acq_index", 32'(index), 4);
      chk("acq_valid", 32'(code_valid), 1);
      chk("acq_err", 32'(err_count), 0);

      // wrap 15 -> 0
      seq(5, 11);
      chk("pre_wrap_idx", 32'(index), 15);
      seq(0, 1);
      chk("wrap_pulse", 32'(wrap_pulse), 1);
      chk("wrap_index", 32'(index), 0);
      chk("wrap_noerr", 32'(err_pulse), 0);
      step(8'h00, 0, 0);
      chk("wrap_one_cyc", 32'(wrap_pulse), 0);

      // skip 3 -> 5
      seq(1, 3);
      seq(5, 1);
      chk("skip_err", 32'(err_pulse), 1);
      chk("skip_cnt", 32'(err_count), 1);
      chk("skip_unlock", 32'(locked), 0);

      // relock with gaps, then hold
      seq(0, 5);
      chk("relock1", 32'(locked), 1);
      step(8'h00, 0, 0);
      seq(5, 1);
      step(8'h00, 0, 0);
      seq(6, 1);
      chk("gap_noerr", 32'(err_count), 1);
      chk("gap_locked", 32'(locked), 1);
      seq(6, 1);
      chk("hold_err", 32'(err_pulse), 1);
      chk("hold_cnt", 32'(err_count), 2);

      // illegal code
      seq(0, 5);
      step(8'h55, 1, 0);
      chk("ill_err", 32'(err_pulse), 1);
      chk("ill_cnt", 32'(err_count), 3);
      chk("ill_valid", 32'(code_valid), 0);
      chk("ill_index", 32'(index), 0);
      chk("ill_locked", 32'(locked), 0);
      step(8'h00, 0, 0);
      chk("ill_one_cyc", 32'(err_pulse), 0);
      seq(7, 4);
      chk("ill_relock_4", 32'(locked), 0);
      seq(11, 1);
      chk("ill_relock_5", 32'(locked), 1);

      // asynchronous reset mid-run
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("arst_locked", 32'(locked), 0);
      chk("arst_err", 32'(err_count), 0);
      chk("arst_index", 32'(index), 0);
      chk("arst_valid", 32'(code_valid), 0);
      chk("arst_pulses", 32'({err_pulse, wrap_pulse}), 0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      step(8'h00, 0, 0);

      // saturation
      for (int i = 0; i < 260; i++) begin
         seq(0, 5);
         step(8'h55, 1, 0);
      end
      chk("sat_cnt", 32'(err_count), 255);
      seq(0, 5);
      step(8'h55, 1, 1);
      chk("clr_with_err", 32'(err_count), 1);
      step(8'h00, 0, 1);
      chk("clr_no_sample", 32'(err_count), 0);

      // random traffic
      for (int i = 0; i < 2000; i++) begin
         int r;
         logic [7:0] c;
         r = int'($urandom_range(0, 99));
         if (r < 75)      c = ref_code((m_prev + 1) % 16);
         else if (r < 82) c = ref_code(m_prev);
         else if (r < 90) c = ref_code(int'($urandom_range(0, 15)));
         else             c = 8'($urandom);
         step(c, ($urandom_range(0, 9) < 8), ($urandom_range(0, 49) == 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
